// File: rtl/spi_bus_pkg.sv
`timescale 1ns/1ps
// Shared types and command-field layout for the SPI-to-register-bus bridge.
package spi_bus_pkg;

  localparam int ADDR_W_DEF    = 7;
  localparam int CMD_WR_BIT    = 7;
  localparam int CMD_PERIPH_HI = 6;
  localparam int CMD_PERIPH_LO = 3;
  localparam int CMD_REG_HI    = 2;
  localparam int CMD_REG_LO    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_WAIT_ACK
  } state_e;

  // Register field wraps mod 8; the peripheral field is carried unchanged.
  function automatic logic [6:0] bus_addr(input logic [7:0] cmd, input logic [2:0] off);
    logic [2:0] reg_idx;
    reg_idx = cmd[CMD_REG_HI:CMD_REG_LO] + off;
    return {cmd[CMD_PERIPH_HI:CMD_PERIPH_LO], reg_idx};
  endfunction

endpackage

// File: rtl/spi_bus_bridge_sync.sv
`timescale 1ns/1ps
// 2-FF synchroniser with a third flop for edge detect; level and edges valid 2 cycles after input.
// No backpressure: pulses are single-cycle and must be consumed when seen.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], async_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= {3{RST_VAL}};
    else          sync_q <= sync_d;
  end

  assign lvl_o  = sync_q[1];
  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_bus_bridge.sv
`timescale 1ns/1ps
// Turns SPI slave byte strobes into single-byte register bus accesses; send byte loads 1 cycle after edge detect.
// One bus request outstanding; strobes arriving while busy are dropped and flagged in the sticky oERR.
module spi_bus_bridge
  import spi_bus_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter int         TIMEOUT   = 16,
  parameter logic [6:0] STATUS_ID = 7'h01
) (
  input  logic              iCLK,
  input  logic              iRESET_n,
  input  logic              iSPI_SS_n,
  input  logic              iSPI_READ_SIG,
  input  logic              iSPI_WRITE_SIG,
  input  logic [7:0]        iSPI_RCV_BYTE,
  input  logic [7:0]        iSPI_RCV_CMD,
  output logic [7:0]        oSPI_SEND_BYTE,
  output logic [ADDR_W-1:0] oBUS_ADDR,
  output logic [7:0]        oBUS_WDATA,
  output logic              oBUS_WR,
  output logic              oBUS_RD,
  input  logic [7:0]        iBUS_RDATA,
  input  logic              iBUS_ACK,
  output logic              oBUSY,
  output logic              oERR
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic ss_lvl, ss_rise, ss_fall, rd_rise, wr_rise;
  logic unused_rd_lvl, unused_rd_fall, unused_wr_lvl, unused_wr_fall;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk_i(iCLK), .rst_n_i(iRESET_n), .async_i(iSPI_SS_n),
    .lvl_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_rd (
    .clk_i(iCLK), .rst_n_i(iRESET_n), .async_i(iSPI_READ_SIG),
    .lvl_o(unused_rd_lvl), .rise_o(rd_rise), .fall_o(unused_rd_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_wr (
    .clk_i(iCLK), .rst_n_i(iRESET_n), .async_i(iSPI_WRITE_SIG),
    .lvl_o(unused_wr_lvl), .rise_o(wr_rise), .fall_o(unused_wr_fall)
  );

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d, next_q, next_d, send_q, send_d, wdata_q, wdata_d;
  logic              cmd_vld_q, cmd_vld_d, err_q, err_d, abort_q, abort_d;
  logic [2:0]        off_q, off_d;
  logic [1:0]        idx_q, idx_d, idx_eff;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              busy, cmd_evt, is_wr;

  // The command strobe may land in the same cycle as SS_n fall, before idx_q is cleared.
  assign idx_eff = ss_fall ? 2'd0 : idx_q;
  assign busy    = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ) || (state_q == ST_WAIT_ACK);
  assign is_wr   = cmd_q[CMD_WR_BIT];
  assign cmd_evt = rd_rise && (idx_eff == 2'd0) && !ss_rise &&
                   (((state_q == ST_IDLE) && ss_fall) || ((state_q == ST_CMD) && !cmd_vld_q));

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cmd_vld_d = cmd_vld_q;
    off_d     = off_q;
    idx_d     = idx_q;
    next_d    = next_q;
    send_d    = send_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    abort_d   = abort_q;
    tmo_d     = tmo_q;

    if (ss_fall)                          idx_d = rd_rise ? 2'd1 : 2'd0;
    else if (rd_rise && idx_q != 2'd3)    idx_d = idx_q + 2'd1;

    if (cmd_evt) begin
      cmd_d     = iSPI_RCV_CMD;
      cmd_vld_d = 1'b1;
      off_d     = 3'd0;
      next_d    = {err_q, STATUS_ID};
    end

    if (busy) begin
      if (ss_rise) abort_d = 1'b1;
      else if (rd_rise || wr_rise) begin
        err_d = 1'b1;
        if (rd_rise && !is_wr && !abort_q) send_d = next_q;
      end
    end

    case (state_q)
      ST_IDLE: if (ss_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (ss_rise) begin
          state_d   = ST_IDLE;
          send_d    = 8'h00;
          cmd_vld_d = 1'b0;
        end else if (cmd_vld_q && is_wr && wr_rise) begin
          addr_d  = ADDR_W'(bus_addr(cmd_q, off_q));
          wdata_d = iSPI_RCV_BYTE;
          off_d   = off_q + 3'd1;
          state_d = ST_WR_REQ;
        end else if (cmd_vld_q && !is_wr && rd_rise && idx_eff != 2'd0) begin
          send_d  = next_q;
          addr_d  = ADDR_W'(bus_addr(cmd_q, off_q));
          off_d   = off_q + 3'd1;
          state_d = ST_RD_REQ;
        end
      end
      ST_WR_REQ, ST_RD_REQ: begin
        state_d = ST_WAIT_ACK;
        tmo_d   = '0;
      end
      ST_WAIT_ACK: begin
        if (iBUS_ACK || tmo_q == TW'(TIMEOUT - 1)) begin
          if (!iBUS_ACK) err_d = 1'b1;
          if (abort_q || ss_rise) begin
            // Result belongs to a finished transaction; a reselect waits for its own command.
            state_d   = ss_lvl ? ST_IDLE : ST_CMD;
            send_d    = 8'h00;
            cmd_vld_d = 1'b0;
            abort_d   = 1'b0;
          end else begin
            state_d = ST_CMD;
            if (!is_wr) next_d = iBUS_ACK ? iBUS_RDATA : 8'hFF;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET_n) begin
    if (!iRESET_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= 8'h00;
      cmd_vld_q <= 1'b0;
      off_q     <= 3'd0;
      idx_q     <= 2'd0;
      next_q    <= 8'h00;
      send_q    <= 8'h00;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cmd_vld_q <= cmd_vld_d;
      off_q     <= off_d;
      idx_q     <= idx_d;
      next_q    <= next_d;
      send_q    <= send_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
      tmo_q     <= tmo_d;
    end
  end

  assign oSPI_SEND_BYTE = send_q;
  assign oBUS_ADDR      = addr_q;
  assign oBUS_WDATA     = wdata_q;
  assign oBUS_WR        = (state_q == ST_WR_REQ) || ((state_q == ST_WAIT_ACK) &&  is_wr);
  assign oBUS_RD        = (state_q == ST_RD_REQ) || ((state_q == ST_WAIT_ACK) && !is_wr);
  assign oBUSY          = (state_q != ST_IDLE);
  assign oERR           = err_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
`timescale 1ns/1ps
// Bench for spi_bus_bridge: drives SPI-side strobes, emulates the register bus, checks against a memory model.
module tb_spi_bus_bridge;

  localparam int TIMEOUT = 16;

  logic       iCLK = 1'b0, iRESET_n = 1'b0;
  logic       ss_n = 1'b1, rd_sig = 1'b0, wr_sig = 1'b0;
  logic [7:0] rcv_byte = 8'h00, rcv_cmd = 8'h00;
  logic [7:0] oSPI_SEND_BYTE, oBUS_WDATA;
  logic [6:0] oBUS_ADDR;
  logic       oBUS_WR, oBUS_RD, oBUSY, oERR;
  logic [7:0] iBUS_RDATA = 8'h00;
  logic       iBUS_ACK = 1'b0;

  spi_bus_bridge dut (
    .iCLK(iCLK), .iRESET_n(iRESET_n), .iSPI_SS_n(ss_n),
    .iSPI_READ_SIG(rd_sig), .iSPI_WRITE_SIG(wr_sig),
    .iSPI_RCV_BYTE(rcv_byte), .iSPI_RCV_CMD(rcv_cmd),
    .oSPI_SEND_BYTE(oSPI_SEND_BYTE), .oBUS_ADDR(oBUS_ADDR), .oBUS_WDATA(oBUS_WDATA),
    .oBUS_WR(oBUS_WR), .oBUS_RD(oBUS_RD), .iBUS_RDATA(iBUS_RDATA), .iBUS_ACK(iBUS_ACK),
    .oBUSY(oBUSY), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int tests = 0, fails = 0;
  logic [7:0] mem [128];
  int ack_en = 1, ack_dly = 2;
  int ack_cnt = 0, rd_hi = 0, bus_cycles = 0;
  int wlog_addr [$];
  logic [7:0] wlog_data [$];
  logic [7:0] wdat [$];
  logic [7:0] miso [$];

  // Register bus responder: acks after ack_dly cycles of a held request, logs writes.
  always @(negedge iCLK) begin
    if (!iRESET_n) begin
      iBUS_ACK = 1'b0;
      ack_cnt  = 0;
    end else if (iBUS_ACK) begin
      iBUS_ACK = 1'b0;
      ack_cnt  = 0;
    end else if ((oBUS_WR || oBUS_RD) && ack_en != 0) begin
      if (ack_cnt >= ack_dly) begin
        iBUS_ACK = 1'b1;
        bus_cycles++;
        if (oBUS_WR) begin
          wlog_addr.push_back(int'(oBUS_ADDR));
          wlog_data.push_back(oBUS_WDATA);
        end else begin
          iBUS_RDATA = mem[oBUS_ADDR];
        end
        ack_cnt = 0;
      end else ack_cnt++;
    end else ack_cnt = 0;
    if (oBUS_RD) rd_hi++;
  end

  function automatic int exp_addr(input logic [7:0] cmd, input int k);
    return int'(cmd[6:3]) * 8 + (int'(cmd[2:0]) + k) % 8;
  endfunction

  // Byte k of a read: 1 is status, k>=2 is register start+(k-2).
  function automatic logic [7:0] exp_miso(input logic [7:0] cmd, input int k, input logic err);
    if (k == 1) return {err, 7'h01};
    return mem[exp_addr(cmd, k - 2)];
  endfunction

  task automatic clk(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic spi_begin(input logic [7:0] cmd, input int lag);
    rcv_cmd = cmd;
    ss_n = 1'b0;
    if (lag > 0) clk(lag);
    rd_sig = 1'b1; clk(6); rd_sig = 1'b0; clk(10);
  endtask

  task automatic spi_end();
    ss_n = 1'b1; clk(12);
  endtask

  task automatic run_write(input logic [7:0] cmd, input int lag);
    spi_begin(cmd, lag);
    foreach (wdat[i]) begin
      rcv_byte = wdat[i]; wr_sig = 1'b1; clk(6); wr_sig = 1'b0; clk(24);
      rd_sig = 1'b1; clk(6); rd_sig = 1'b0; clk(6);
    end
    spi_end();
  endtask

  task automatic read_bytes(input int n);
    miso.delete();
    repeat (n) begin
      rd_sig = 1'b1; clk(4);
      miso.push_back(oSPI_SEND_BYTE);
      clk(2); rd_sig = 1'b0; clk(30);
    end
  endtask

  task automatic test_reset();
    iRESET_n = 1'b0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    clk(3);
    tests++; if (oSPI_SEND_BYTE !== 8'h00) begin fails++; $display("FAIL reset_send: got %h want 00", oSPI_SEND_BYTE); end
    tests++; if (oBUS_ADDR !== 7'h00 || oBUS_WDATA !== 8'h00) begin fails++; $display("FAIL reset_bus: addr %h wdata %h want 0", oBUS_ADDR, oBUS_WDATA); end
    tests++; if ({oBUS_WR, oBUS_RD, oBUSY, oERR} !== 4'b0) begin fails++; $display("FAIL reset_ctl: wr/rd/busy/err %b want 0000", {oBUS_WR, oBUS_RD, oBUSY, oERR}); end
    iRESET_n = 1'b1;
    clk(5);
  endtask

  task automatic test_write_directed();
    logic [7:0] cmds [3];
    int nb [3];
    int base;
    cmds[0] = 8'h8A; cmds[1] = 8'h8E; cmds[2] = 8'h8F;
    nb[0] = 3; nb[1] = 2; nb[2] = 2;
    ack_dly = 2;
    for (int t = 0; t < 3; t++) begin
      wdat.delete();
      if (t == 0) begin wdat.push_back(8'h11); wdat.push_back(8'h22); wdat.push_back(8'h33); end
      else if (t == 1) begin wdat.push_back(8'hAA); wdat.push_back(8'hBB); end
      else begin wdat.push_back(8'hCC); wdat.push_back(8'hDD); end
      base = wlog_addr.size();
      run_write(cmds[t], 0);
      tests++;
      if (wlog_addr.size() - base != nb[t]) begin
        fails++; $display("FAIL wr_count cmd %h: got %0d want %0d", cmds[t], wlog_addr.size() - base, nb[t]);
      end else begin
        for (int i = 0; i < nb[t]; i++) begin
          tests++;
          if (wlog_addr[base+i] !== exp_addr(cmds[t], i) || wlog_data[base+i] !== wdat[i]) begin
            fails++; $display("FAIL wr_beat cmd %h #%0d: got %h=%h want %h=%h", cmds[t], i,
                              wlog_addr[base+i], wlog_data[base+i], exp_addr(cmds[t], i), wdat[i]);
          end
          mem[exp_addr(cmds[t], i)] = wdat[i];
        end
      end
    end
    // 0x8F: second beat must wrap to register 0 of peripheral 1 (0x08)
    tests++; if (wlog_addr[wlog_addr.size()-1] !== 8) begin fails++; $display("FAIL wr_wrap: got %h want 08", wlog_addr[wlog_addr.size()-1]); end
    tests++; if (oERR !== 1'b0) begin fails++; $display("FAIL wr_err: got %b want 0", oERR); end
  endtask

  task automatic test_write_random();
    logic [7:0] cmd;
    int n, base;
    repeat (4) begin
      cmd = 8'h80 | 8'($urandom_range(0, 127));
      n = $urandom_range(1, 4);
      ack_dly = $urandom_range(1, 4);
      wdat.delete();
      repeat (n) wdat.push_back(8'($urandom));
      base = wlog_addr.size();
      run_write(cmd, $urandom_range(0, 3));
      tests++;
      if (wlog_addr.size() - base != n) begin
        fails++; $display("FAIL wr_rand_count cmd %h: got %0d want %0d", cmd, wlog_addr.size() - base, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          tests++;
          if (wlog_addr[base+i] !== exp_addr(cmd, i) || wlog_data[base+i] !== wdat[i]) begin
            fails++; $display("FAIL wr_rand cmd %h #%0d: got %h=%h want %h=%h", cmd, i,
                              wlog_addr[base+i], wlog_data[base+i], exp_addr(cmd, i), wdat[i]);
          end
          mem[exp_addr(cmd, i)] = wdat[i];
        end
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] exp3 [3];
    logic [7:0] cmd;
    int n;
    exp3[0] = 8'h01; exp3[1] = 8'hC3; exp3[2] = 8'h5A;
    mem[7'h10] = 8'hC3; mem[7'h11] = 8'h5A;
    ack_dly = 2;
    spi_begin(8'h10, 0);
    read_bytes(3);
    spi_end();
    for (int k = 0; k < 3; k++) begin
      tests++; if (miso[k] !== exp3[k]) begin fails++; $display("FAIL rd_dir byte %0d: got %h want %h", k + 1, miso[k], exp3[k]); end
    end
    tests++; if (oSPI_SEND_BYTE !== 8'h00 || oBUSY !== 1'b0) begin fails++; $display("FAIL rd_end: send %h busy %b want 00 0", oSPI_SEND_BYTE, oBUSY); end
    repeat (4) begin
      cmd = 8'($urandom_range(0, 127));
      n = $urandom_range(2, 5);
      ack_dly = $urandom_range(1, 4);
      spi_begin(cmd, $urandom_range(0, 3));
      read_bytes(n);
      spi_end();
      for (int k = 0; k < n; k++) begin
        tests++;
        if (miso[k] !== exp_miso(cmd, k + 1, 1'b0)) begin
          fails++; $display("FAIL rd_rand cmd %h byte %0d: got %h want %h", cmd, k + 1, miso[k], exp_miso(cmd, k + 1, 1'b0));
        end
      end
    end
  endtask

  task automatic test_ss_abort();
    int base, cyc;
    ack_dly = 10;
    base = wlog_addr.size();
    spi_begin(8'h8A, 0);
    rcv_byte = 8'h77; wr_sig = 1'b1; clk(5);
    ss_n = 1'b1; wr_sig = 1'b0; clk(4);
    tests++; if (oBUSY !== 1'b1 || oBUS_WR !== 1'b1) begin fails++; $display("FAIL abort_held: busy %b wr %b want 1 1", oBUSY, oBUS_WR); end
    clk(30);
    tests++;
    if (wlog_addr.size() - base != 1 || wlog_addr[wlog_addr.size()-1] !== 8'h0A || wlog_data[wlog_data.size()-1] !== 8'h77) begin
      fails++; $display("FAIL abort_write: count %0d last %h=%h want 1 0a=77", wlog_addr.size() - base,
                        wlog_addr[wlog_addr.size()-1], wlog_data[wlog_data.size()-1]);
    end
    mem[7'h0A] = 8'h77;
    tests++; if (oBUSY !== 1'b0 || oSPI_SEND_BYTE !== 8'h00 || oERR !== 1'b0) begin fails++; $display("FAIL abort_idle: busy %b send %h err %b want 0 00 0", oBUSY, oSPI_SEND_BYTE, oERR); end
    cyc = bus_cycles;
    rd_sig = 1'b1; clk(6); rd_sig = 1'b0; clk(30);
    tests++; if (bus_cycles != cyc || oBUSY !== 1'b0) begin fails++; $display("FAIL abort_quiet: bus cycles %0d busy %b want %0d 0", bus_cycles, oBUSY, cyc); end
    ack_dly = 2;
  endtask

  task automatic test_timeout();
    int rd0;
    ack_en = 0;
    spi_begin(8'h20, 0);
    rd0 = rd_hi;
    read_bytes(1);
    tests++; if (miso[0] !== 8'h01) begin fails++; $display("FAIL tmo_status: got %h want 01", miso[0]); end
    tests++; if (rd_hi - rd0 != TIMEOUT + 1) begin fails++; $display("FAIL tmo_len: rd high %0d cycles want %0d", rd_hi - rd0, TIMEOUT + 1); end
    tests++; if (oBUS_RD !== 1'b0 || oERR !== 1'b1) begin fails++; $display("FAIL tmo_state: rd %b err %b want 0 1", oBUS_RD, oERR); end
    read_bytes(1);
    tests++; if (miso[0] !== 8'hFF) begin fails++; $display("FAIL tmo_ff: got %h want ff", miso[0]); end
    spi_end();
    ack_en = 1;
    spi_begin(8'h10, 1);
    read_bytes(2);
    spi_end();
    tests++; if (miso[0] !== 8'h81) begin fails++; $display("FAIL tmo_sticky: got %h want 81", miso[0]); end
    tests++; if (miso[1] !== exp_miso(8'h10, 2, 1'b1)) begin fails++; $display("FAIL tmo_recover: got %h want %h", miso[1], exp_miso(8'h10, 2, 1'b1)); end
  endtask

  task automatic test_reset_mid();
    ack_dly = 12;
    spi_begin(8'h10, 0);
    rd_sig = 1'b1; clk(6);
    iRESET_n = 1'b0;
    #1;
    tests++; if (oBUS_RD !== 1'b0 || oBUSY !== 1'b0 || oERR !== 1'b0) begin fails++; $display("FAIL rst_mid_ctl: rd %b busy %b err %b want 000", oBUS_RD, oBUSY, oERR); end
    tests++; if (oSPI_SEND_BYTE !== 8'h00 || oBUS_ADDR !== 7'h00) begin fails++; $display("FAIL rst_mid_data: send %h addr %h want 0", oSPI_SEND_BYTE, oBUS_ADDR); end
    ss_n = 1'b1; rd_sig = 1'b0;
    clk(4); iRESET_n = 1'b1; clk(4);
    ack_dly = 2;
    spi_begin(8'h13, 0);
    read_bytes(3);
    spi_end();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (miso[k] !== exp_miso(8'h13, k + 1, 1'b0)) begin
        fails++; $display("FAIL rst_after byte %0d: got %h want %h", k + 1, miso[k], exp_miso(8'h13, k + 1, 1'b0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_directed();
    test_write_random();
    test_read();
    test_ss_abort();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_bus_bridge.md
Name: spi_bus_bridge

Overview:
- Downstream of the SPI slave front-end; consumes its strobes, command and received bytes, and supplies its transmit byte.
- Converts SPI transactions into single-byte accesses on the FPGA-internal register bus in the iCLK domain.
- Handles clock-domain crossing, address auto-increment, read prefetch, bus handshake and timeout.

Parameters:
- ADDR_W, 7, bus address width; address = {peripheral[3:0], register[2:0]}.
- TIMEOUT, 16, iCLK cycles allowed for iBUS_ACK before the access is aborted.
- STATUS_ID, 7'h01, low 7 bits of the status byte returned in data byte 1 of a read.

Ports:
- iCLK  in  1  system clock.
- iRESET_n  in  1  asynchronous active-low reset.
- iSPI_SS_n  in  1  slave select (SCK domain, async to iCLK).
- iSPI_READ_SIG  in  1  byte-boundary strobe from the SPI slave (async).
- iSPI_WRITE_SIG  in  1  data-byte-complete strobe for write commands (async).
- iSPI_RCV_BYTE  in  8  received data byte; quasi-static while iSPI_WRITE_SIG is high.
- iSPI_RCV_CMD  in  8  command: [7]=write, [6:3]=peripheral, [2:0]=start register.
- oSPI_SEND_BYTE  out  8  byte shifted out by the SPI slave.
- oBUS_ADDR  out  ADDR_W  bus address.
- oBUS_WDATA  out  8  bus write data.
- oBUS_WR  out  1  write request, held until ack or timeout.
- oBUS_RD  out  1  read request, held until ack or timeout.
- iBUS_RDATA  in  8  read data, valid with iBUS_ACK.
- iBUS_ACK  in  1  single-cycle access acknowledge.
- oBUSY  out  1  FSM not IDLE.
- oERR  out  1  sticky error: timeout or overrun; cleared only by reset.

Behaviour:
- Clock ratio: SCK half-period must be at least 4 iCLK periods. This is a system constraint.
- Reset (async, iRESET_n low): all outputs 0, FSM=IDLE, sync flops set so that SS_n reads 1 and strobes read 0. oSPI_SEND_BYTE=8'h00.
- CDC: 2-FF synchronisers on iSPI_SS_n, iSPI_READ_SIG and iSPI_WRITE_SIG. A third flop provides rising-edge detect for the strobes and falling-edge detect for SS_n.
- Data sampling: iSPI_RCV_CMD and iSPI_RCV_BYTE are sampled only on the iCLK cycle of a detected edge. They are never sampled otherwise.
- Byte index: rBYTE_IDX (saturating at 3) is cleared on SS_n fall and incremented on each READ_SIG rise. The first rise (byte 0, command) occurs at SS_n fall.
- FSM states:
  - IDLE.
  - CMD: waits for the READ_SIG rise with rBYTE_IDX=0→1, then latches rCMD and sets rOFFSET=0.
  - WR_REQ.
  - RD_REQ.
  - WAIT_ACK.
- Write command (rCMD[7]=1):
  - Each WRITE_SIG rise goes to WR_REQ, then WAIT_ACK.
  - Issues oBUS_ADDR={rCMD[6:3], rCMD[2:0]+rOFFSET}, oBUS_WDATA=sampled byte, then rOFFSET++.
- Read command (rCMD[7]=0), on each READ_SIG rise with index≥1:
  - oSPI_SEND_BYTE<=rNEXT, loaded within 1 cycle of edge detect (≤4 iCLK after the SCK edge). The MSB is therefore stable before the master samples.
  - Then issues a bus read at {rCMD[6:3], rCMD[2:0]+rOFFSET}, rOFFSET++, result → rNEXT.
  - Byte 1 returns the status byte {oERR, STATUS_ID}. Byte k≥2 returns register start+(k-2).
- Register wrap: the register field wraps mod 8 and the peripheral field never changes within a transaction.
- Bus handshake:
  - oBUS_WR/oBUS_RD asserted from the REQ cycle until the cycle iBUS_ACK=1, then deasserted the next cycle.
  - At most one request is outstanding.
  - ACK outside WAIT_ACK is ignored.
- Timeout: TIMEOUT cycles in WAIT_ACK without ack → drop the request, rNEXT=8'hFF on reads, set oERR, return to the transaction state.
- Overrun: a WRITE_SIG or READ_SIG rise while in REQ/WAIT_ACK sets oERR. That byte is dropped (write) or the stale rNEXT is sent (read).
- SS_n rise:
  - Transaction ends. Any outstanding access completes its handshake or times out, and its result is discarded.
  - Then IDLE, with oSPI_SEND_BYTE=8'h00.
- SS_n fall while still in WAIT_ACK: the new transaction starts after the access finishes. If command detection is missed, oERR is set.
- Simultaneous SS_n rise and a strobe edge: SS_n wins and the strobe is ignored.

Decomposition:
- Package spi_bus_pkg: FSM state enum, command field positions (CMD_WR_BIT=7, CMD_PERIPH=[6:3], CMD_REG=[2:0]), ADDR_W default.
- Sub-module spi_sync_edge: 2-FF synchroniser plus edge detector, instantiated three times. Outputs sync level, rise and fall.

Test Plan:
- Write cmd 8'h8A (periph 1, reg 2), data 8'h11, 8'h22, 8'h33, bus acks after 2 cycles → bus writes 0x0A=0x11, 0x0B=0x22, 0x0C=0x33; oERR=0.
- Write cmd 8'h8E, data 8'hAA, 8'hBB → writes to 0x0E and 0x0F; cmd 8'h8F with 2 bytes → 0x0F then wraps to 0x08 (not 0x10).
- Read cmd 8'h10 (periph 2, reg 0), regs 0x10=0xC3, 0x11=0x5A, 3 data bytes clocked → MISO bytes 0x01 (status), 0xC3, 0x5A.
- Read with iBUS_ACK never asserted → after 16 cycles oBUS_RD drops, next byte returns 0xFF, oERR=1, next read's status byte=0x81.
- SS_n deasserted while a write is in WAIT_ACK → access completes on ack, FSM returns to IDLE, oBUSY=0, oSPI_SEND_BYTE=0x00, no further bus cycle.
- iRESET_n pulsed low mid-read → all outputs 0 immediately (async), oERR cleared, next transaction behaves normally.
